// File: rtl/life_loss_pkg.sv
// Shared state encoding and default timing constants for the life-loss requester.
package life_loss_pkg;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_REQUEST = 2'd1;
  localparam logic [1:0] ST_INVULN  = 2'd2;
  localparam logic [1:0] ST_DEAD    = 2'd3;

  typedef enum logic [1:0] {
    IDLE    = ST_IDLE,
    REQUEST = ST_REQUEST,
    INVULN  = ST_INVULN,
    DEAD    = ST_DEAD
  } state_t;

  localparam int DEFAULT_INVULN_CYCLES   = 50_000_000;
  localparam int DEFAULT_BLINK_CYCLES    = 6_250_000;
  localparam int DEFAULT_HIT_COUNT_WIDTH = 8;

  // A counter that must hold cycles-1 needs at least one bit even for cycles==1.
  function automatic int timer_width(input int cycles);
    return (cycles > 1) ? $clog2(cycles) : 1;
  endfunction

endpackage

// File: rtl/life_loss_requester_if.sv
// Handshake and status bundle between collision logic, lives block and requester.
interface life_loss_requester_if
  import life_loss_pkg::*;
#(
  parameter int HIT_COUNT_WIDTH = DEFAULT_HIT_COUNT_WIDTH
);
  logic                       collision;
  logic                       ready;
  logic                       gameOver;
  logic                       enable;
  logic                       invulnerable;
  logic                       blink;
  logic [HIT_COUNT_WIDTH-1:0] hitCount;

  modport master (
    input  collision, ready, gameOver,
    output enable, invulnerable, blink, hitCount
  );

  modport slave (
    output collision, ready, gameOver,
    input  enable, invulnerable, blink, hitCount
  );
endinterface

// File: rtl/invuln_timer.sv
// Loadable down-counter; counts to zero and stops there. zero reflects the current count.
module invuln_timer #(
  parameter int WIDTH = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] loadValue,
  output logic             zero
);
  logic [WIDTH-1:0] count;

  always_ff @(posedge clock) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= loadValue;
    end else if (count != '0) begin
      count <= count - WIDTH'(1);
    end
  end

  assign zero = (count == '0);
endmodule

// File: rtl/life_loss_requester.sv
// Raises one life-loss request per hit, holds it until acknowledged, then an invulnerability window.
// Blink strobe is generated only when LIFE_LOSS_BLINK_EN is defined; otherwise blink is tied high.
module life_loss_requester
  import life_loss_pkg::*;
#(
  parameter int INVULN_CYCLES   = DEFAULT_INVULN_CYCLES,
  parameter int BLINK_CYCLES    = DEFAULT_BLINK_CYCLES,
  parameter int HIT_COUNT_WIDTH = DEFAULT_HIT_COUNT_WIDTH
) (
  input logic                   clock,
  input logic                   reset,
  life_loss_requester_if.master bus
);
  localparam int TIMER_WIDTH = timer_width(INVULN_CYCLES);
  localparam logic [TIMER_WIDTH-1:0] INVULN_LOAD = TIMER_WIDTH'(INVULN_CYCLES - 1);

  if (INVULN_CYCLES < 1 || BLINK_CYCLES < 1) begin : g_bad_cycles
    $error("life_loss_requester: INVULN_CYCLES and BLINK_CYCLES must be >= 1");
  end

  state_t                     state;
  state_t                     state_next;
  logic                       accept;
  logic                       invuln_zero;
  logic                       req_active;
  logic                       invuln_active;
  logic [HIT_COUNT_WIDTH-1:0] hit_count;

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        if (bus.collision && bus.ready) begin
          state_next = REQUEST;
        end
      end
      REQUEST: begin
        if (!bus.ready) begin
          accept     = 1'b1;
          state_next = INVULN;
        end
      end
      INVULN: begin
        if (invuln_zero) begin
          state_next = IDLE;
        end
      end
      DEAD: begin
        state_next = DEAD;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
    // accept stays set so a hit acknowledged in the same cycle as game over still counts
    if (bus.gameOver) begin
      state_next = DEAD;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      req_active    <= 1'b0;
      invuln_active <= 1'b0;
      hit_count     <= '0;
    end else begin
      req_active    <= (state_next == REQUEST);
      invuln_active <= (state_next == INVULN);
      if (accept && (hit_count != '1)) begin
        hit_count <= hit_count + HIT_COUNT_WIDTH'(1);
      end
    end
  end

  invuln_timer #(
    .WIDTH (TIMER_WIDTH)
  ) u_invuln_timer (
    .clock     (clock),
    .reset     (reset),
    .load      (accept),
    .loadValue (INVULN_LOAD),
    .zero      (invuln_zero)
  );

`ifdef LIFE_LOSS_BLINK_EN
  localparam int BLINK_WIDTH = timer_width(BLINK_CYCLES);
  localparam logic [BLINK_WIDTH-1:0] BLINK_LOAD = BLINK_WIDTH'(BLINK_CYCLES - 1);

  logic blink_zero;
  logic blink_load;
  logic blink_level;

  // Restart the half-period on window entry and on every toggle.
  assign blink_load = accept || ((state == INVULN) && blink_zero);

  invuln_timer #(
    .WIDTH (BLINK_WIDTH)
  ) u_blink_timer (
    .clock     (clock),
    .reset     (reset),
    .load      (blink_load),
    .loadValue (BLINK_LOAD),
    .zero      (blink_zero)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      blink_level <= 1'b0;
    end else begin
      case (state_next)
        INVULN:  blink_level <= accept ? 1'b0 : (blink_zero ? ~blink_level : blink_level);
        DEAD:    blink_level <= 1'b0;
        default: blink_level <= 1'b1;
      endcase
    end
  end

  assign bus.blink = blink_level;
`else
  assign bus.blink = 1'b1;
`endif

  assign bus.enable       = req_active;
  assign bus.invulnerable = invuln_active;
  assign bus.hitCount     = hit_count;
endmodule
